// File: rtl/mc_main_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_main_fsm_if
//   Request/ready handshake between the main controller FSM and the stallable
//   unified instruction/data memory.
//
//   Signals
//     mem_req   : controller -> memory, an access is pending this cycle
//     mem_ready : memory -> controller, the pending access completes this cycle
//
//   Modports
//     master : controller side (drives mem_req, samples mem_ready)
//     slave  : memory side     (samples mem_req, drives mem_ready)
// -----------------------------------------------------------------------------
interface mc_main_fsm_if;
    logic mem_req;
    logic mem_ready;

    modport master (output mem_req, input mem_ready);
    modport slave  (input mem_req, output mem_ready);
endinterface : mc_main_fsm_if

// File: rtl/mc_main_fsm.sv
// -----------------------------------------------------------------------------
// mc_main_fsm
//   Main sequencing FSM of the multi-cycle RV32I controller. Decodes the opcode
//   and steps the shared datapath through fetch, decode, execute, memory and
//   writeback. Memory accesses use a req/ready handshake with an optional
//   timeout; an illegal opcode or a timed-out access parks the FSM in TRAP
//   until reset. Completed instructions are counted in instret.
//
//   Parameters
//     CNT_W   : width of the retired-instruction counter
//     TIMEOUT : max wait cycles for mem_ready per access, 0 disables
//
//   Ports
//     clk, reset_n : clock (rising edge), asynchronous active-low reset
//     op           : opcode bits [6:0] from the instruction register
//     zero         : ALU zero flag (used by BEQ)
//     mem          : memory handshake (mem_req out, mem_ready in)
//     PCWrite      : PC enable = PCUpdate | (Branch & zero)
//     AdrSrc       : memory address select, 0 = PC, 1 = ALUOut
//     MemWrite     : memory write strobe
//     IRWrite      : instruction register / OldPC enable
//     RegWrite     : register file write enable
//     ResultSrc    : 00 = ALUOut, 01 = Data, 10 = ALUResult
//     ALUSrcA      : 00 = PC, 01 = OldPC, 10 = RD1
//     ALUSrcB      : 00 = RD2, 01 = ImmExt, 10 = constant 4
//     ALUOp        : 00 = add, 01 = sub, 10 = funct-decoded, 11 = lui
//     retire       : one-cycle pulse in the cycle an instruction completes
//     instret      : retired-instruction count, wraps to 0
//     halted       : FSM is in TRAP
//     trap_cause   : 00 = none, 01 = illegal opcode, 10 = memory timeout
// -----------------------------------------------------------------------------
module mc_main_fsm #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic             zero,
    mc_main_fsm_if.master    mem,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       trap_cause
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Wait counter only needs to reach TIMEOUT; keep at least one bit.
    localparam int              WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_JAL, S_ALUWB, S_BEQ, S_TRAP
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   instret_q;

    logic pc_update;
    logic branch;
    logic waiting;
    logic timed_out;

    // NOTE: all state lives in one async-reset block with non-blocking
    // assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_q + CNT_W'(retire);
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        wait_d      = wait_q;
        mem.mem_req = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        retire      = 1'b0;

        waiting   = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);
        // A ready in the same cycle the count hits the limit wins over timeout.
        timed_out = (TIMEOUT != 0) && (wait_q == WAIT_MAX) && !mem.mem_ready;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem.mem_req = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                if (mem.mem_ready) begin
                    IRWrite   = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                AdrSrc      = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEMWRITE: begin
                // Address and strobe stay stable for the whole stalled access.
                mem.mem_req = 1'b1;
                AdrSrc      = 1'b1;
                MemWrite    = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end

            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end

            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end

            S_LUI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                state_d = S_ALUWB;
            end

            S_JAL: begin
                // ALU forms OldPC+4 (link) while PC takes the jump target in ALUOut.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_IDLE;
        endcase

        // Counter restarts on entry to a waiting state and counts stall cycles.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && !mem.mem_ready && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    assign PCWrite    = pc_update | (branch & zero);
    assign instret    = instret_q;
    assign halted     = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule : mc_main_fsm

// File: tb/tb_mc_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_main_fsm
//   Directed bench for mc_main_fsm (TIMEOUT = 4, CNT_W = 3 so the counter
//   wraps within a short program). Inputs change on the falling edge; outputs
//   are compared 1 ns later against hand-computed control words.
// -----------------------------------------------------------------------------
module tb_mc_main_fsm;

    // Control word layout:
    // {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    //  ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0], retire, halted}
    localparam logic [15:0] E_IDLE    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_FETCH_W = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_FETCH_R = {6'b110010, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_DECODE  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMADR  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMREAD = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMWB   = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] E_MW_W    = {6'b101100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_MW_R    = {6'b101100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] E_EXECR   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [15:0] E_EXECI   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [15:0] E_LUI     = {6'b000000, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
    localparam logic [15:0] E_JAL     = {6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_ALUWB   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] E_BEQ_Z   = {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    localparam logic [15:0] E_BEQ_NZ  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    localparam logic [15:0] E_TRAP    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_cause;
    logic [2:0] instret;
    logic [15:0] ctl;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mc_main_fsm_if mif ();

    mc_main_fsm #(.CNT_W(3), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .mem        (mif),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .retire     (retire),
        .instret    (instret),
        .halted     (halted),
        .trap_cause (trap_cause)
    );

    assign ctl = {mif.mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, then compare the control word.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [15:0] exp);
        @(negedge clk);
        mif.mem_ready = mr;
        zero          = z;
        #1;
        check(tag, {16'h0, ctl}, {16'h0, exp});
    endtask

    initial begin
        reset_n       = 1'b0;
        mif.mem_ready = 1'b0;
        zero          = 1'b0;
        op            = OP_RTYPE;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {16'h0, ctl}, {16'h0, E_IDLE});
        check("rst_instret", {29'h0, instret}, 32'd0);
        check("rst_cause", {30'h0, trap_cause}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("idle_ctl", {16'h0, ctl}, {16'h0, E_IDLE});

        // add: FETCH, DECODE, EXECR, ALUWB
        cyc("add_fetch", 1'b1, 1'b0, E_FETCH_R);
        cyc("add_decode", 1'b1, 1'b0, E_DECODE);
        cyc("add_execr", 1'b1, 1'b0, E_EXECR);
        check("add_instret_pre", {29'h0, instret}, 32'd0);
        cyc("add_aluwb", 1'b1, 1'b0, E_ALUWB);
        op = OP_LOAD;

        // lw with 3 stall cycles in FETCH and MEMREAD: 11 cycles
        cyc("lw_fetch_w0", 1'b0, 1'b0, E_FETCH_W);
        check("add_instret_post", {29'h0, instret}, 32'd1);
        cyc("lw_fetch_w1", 1'b0, 1'b0, E_FETCH_W);
        cyc("lw_fetch_w2", 1'b0, 1'b0, E_FETCH_W);
        cyc("lw_fetch_r", 1'b1, 1'b0, E_FETCH_R);
        cyc("lw_decode", 1'b0, 1'b0, E_DECODE);
        cyc("lw_memadr", 1'b0, 1'b0, E_MEMADR);
        cyc("lw_memrd_w0", 1'b0, 1'b0, E_MEMREAD);
        cyc("lw_memrd_w1", 1'b0, 1'b0, E_MEMREAD);
        cyc("lw_memrd_w2", 1'b0, 1'b0, E_MEMREAD);
        cyc("lw_memrd_r", 1'b1, 1'b0, E_MEMREAD);
        cyc("lw_memwb", 1'b0, 1'b0, E_MEMWB);
        op = OP_BRANCH;

        // beq taken then not taken; both retire
        cyc("beq1_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("lw_instret", {29'h0, instret}, 32'd2);
        cyc("beq1_decode", 1'b0, 1'b0, E_DECODE);
        cyc("beq1_taken", 1'b0, 1'b1, E_BEQ_Z);
        cyc("beq2_fetch", 1'b1, 1'b0, E_FETCH_R);
        cyc("beq2_decode", 1'b0, 1'b0, E_DECODE);
        cyc("beq2_not_taken", 1'b0, 1'b0, E_BEQ_NZ);
        op = OP_STORE;

        // sw with 2 stall cycles: MemWrite held 3 cycles, then FETCH
        cyc("sw_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("beq_instret", {29'h0, instret}, 32'd4);
        cyc("sw_decode", 1'b0, 1'b0, E_DECODE);
        cyc("sw_memadr", 1'b0, 1'b0, E_MEMADR);
        cyc("sw_memwr_w0", 1'b0, 1'b0, E_MW_W);
        cyc("sw_memwr_w1", 1'b0, 1'b0, E_MW_W);
        cyc("sw_memwr_r", 1'b1, 1'b0, E_MW_R);
        op = OP_ITYPE;

        // addi, lui, jal
        cyc("addi_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("sw_instret", {29'h0, instret}, 32'd5);
        cyc("addi_decode", 1'b0, 1'b0, E_DECODE);
        cyc("addi_execi", 1'b0, 1'b0, E_EXECI);
        cyc("addi_aluwb", 1'b0, 1'b0, E_ALUWB);
        op = OP_LUI;
        cyc("lui_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("addi_instret", {29'h0, instret}, 32'd6);
        cyc("lui_decode", 1'b0, 1'b0, E_DECODE);
        cyc("lui_exec", 1'b0, 1'b0, E_LUI);
        cyc("lui_aluwb", 1'b0, 1'b0, E_ALUWB);
        op = OP_JAL;
        cyc("jal_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("lui_instret", {29'h0, instret}, 32'd7);
        cyc("jal_decode", 1'b0, 1'b0, E_DECODE);
        cyc("jal_exec", 1'b0, 1'b0, E_JAL);
        cyc("jal_aluwb", 1'b0, 1'b0, E_ALUWB);
        op = OP_RTYPE;

        // 8th retire wraps the 3-bit counter
        cyc("add2_fetch", 1'b1, 1'b0, E_FETCH_R);
        check("instret_wrap", {29'h0, instret}, 32'd0);
        cyc("add2_decode", 1'b0, 1'b0, E_DECODE);
        cyc("add2_execr", 1'b0, 1'b0, E_EXECR);
        cyc("add2_aluwb", 1'b0, 1'b0, E_ALUWB);
        op = OP_BAD;

        // Ready at count == TIMEOUT completes the fetch; illegal op traps
        cyc("bad_fetch_w0", 1'b0, 1'b0, E_FETCH_W);
        cyc("bad_fetch_w1", 1'b0, 1'b0, E_FETCH_W);
        cyc("bad_fetch_w2", 1'b0, 1'b0, E_FETCH_W);
        cyc("bad_fetch_w3", 1'b0, 1'b0, E_FETCH_W);
        cyc("bad_fetch_r_at_limit", 1'b1, 1'b0, E_FETCH_R);
        cyc("bad_decode", 1'b0, 1'b0, E_DECODE);
        cyc("bad_trap", 1'b0, 1'b0, E_TRAP);
        check("bad_cause", {30'h0, trap_cause}, 32'd1);
        cyc("bad_trap_hold", 1'b1, 1'b1, E_TRAP);
        check("bad_cause_hold", {30'h0, trap_cause}, 32'd1);
        check("bad_instret", {29'h0, instret}, 32'd1);

        // Reset leaves TRAP
        #2 reset_n = 1'b0;
        #1;
        check("trap_rst_ctl", {16'h0, ctl}, {16'h0, E_IDLE});
        check("trap_rst_instret", {29'h0, instret}, 32'd0);
        check("trap_rst_cause", {30'h0, trap_cause}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        op      = OP_RTYPE;

        // mem_ready stuck low in FETCH: 5 FETCH cycles then TRAP cause 10
        cyc("to_fetch_w0", 1'b0, 1'b0, E_FETCH_W);
        cyc("to_fetch_w1", 1'b0, 1'b0, E_FETCH_W);
        cyc("to_fetch_w2", 1'b0, 1'b0, E_FETCH_W);
        cyc("to_fetch_w3", 1'b0, 1'b0, E_FETCH_W);
        cyc("to_fetch_w4", 1'b0, 1'b0, E_FETCH_W);
        cyc("to_trap", 1'b0, 1'b0, E_TRAP);
        check("to_cause", {30'h0, trap_cause}, 32'd2);

        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        op      = OP_STORE;

        // Reset in the middle of a stalled store: strobes drop, nothing retires
        cyc("abort_fetch", 1'b1, 1'b0, E_FETCH_R);
        cyc("abort_decode", 1'b0, 1'b0, E_DECODE);
        cyc("abort_memadr", 1'b0, 1'b0, E_MEMADR);
        cyc("abort_memwr_w", 1'b0, 1'b0, E_MW_W);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ctl", {16'h0, ctl}, {16'h0, E_IDLE});
        mif.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("abort_instret", {29'h0, instret}, 32'd0);
        check("abort_ctl_held", {16'h0, ctl}, {16'h0, E_IDLE});
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mc_main_fsm
